// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter that shares one UART transmitter among NUM_REQ byte
//   sources. A grant is held until the source's last byte is accepted. The arbiter then waits
//   for that byte to leave the one-entry holding register, inserts GAP_CYCLES idle cycles and
//   re-arbitrates.
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   req_valid/data/last : per-source byte stream; source i data at [i*WORD_LEN +: WORD_LEN]
//   req_ready       : per-source accept; only the granted bit can be set
//   tx_data, tx_data_valid / tx_data_ready : holding register towards the UART
//   grant_id        : index of the current or most recently granted source
//   busy            : arbiter is not idle

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_LEN   = 8,
    parameter int unsigned GAP_CYCLES = 16,
    localparam int unsigned GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WORD_LEN-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [WORD_LEN-1:0]         tx_data,
    output logic                        tx_data_valid,
    input  logic                        tx_data_ready,
    output logic [GID_W-1:0]            grant_id,
    output logic                        busy
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);
    localparam logic [GAP_W-1:0] GAP_TERM  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain, StGap} state_e;

    state_e              state;
    logic [GID_W-1:0]    last_grant;
    logic [GAP_W-1:0]    gap_cnt;

    logic                can_load;
    logic                xfer_load;
    logic                sel_valid;
    logic                sel_last;
    logic [WORD_LEN-1:0] sel_data;
    logic                arb_found;
    logic [GID_W-1:0]    arb_pick;
    logic [GID_W-1:0]    arb_idx;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = last_grant;
        arb_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            arb_idx = GID_W'((32'(last_grant) + i) % NUM_REQ);
            if (!arb_found && req_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx;
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[32'(grant_id) * WORD_LEN +: WORD_LEN];

    // Holding register can take a new byte when empty or emptying this cycle.
    assign can_load  = !tx_data_valid || tx_data_ready;
    assign xfer_load = (state == StXfer) && can_load && sel_valid;
    assign busy      = (state != StIdle);

    always_comb begin
        req_ready = '0;
        if (state == StXfer && can_load) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            last_grant    <= LAST_INIT;
            gap_cnt       <= '0;
        end else begin
            // A load in the same cycle as a UART handshake replaces the byte and keeps valid.
            if (xfer_load) begin
                tx_data       <= sel_data;
                tx_data_valid <= 1'b1;
            end else if (tx_data_ready) begin
                tx_data_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (arb_found) begin
                        grant_id   <= arb_pick;
                        last_grant <= arb_pick;
                        state      <= StXfer;
                    end
                end
                StXfer: begin
                    if (xfer_load && sel_last) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (can_load) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? StIdle : StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt == GAP_TERM) begin
                        gap_cnt <= '0;
                        state   <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a byte-source model per requester and a scoreboard of
// expected UART bytes in predicted arbitration order.

module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned WL  = 8;
    localparam int unsigned GAP = 16;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*WL-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [WL-1:0]     tx_data;
    logic              tx_data_valid;
    logic              tx_data_ready;
    logic [1:0]        grant_id;
    logic              busy;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .WORD_LEN  (WL),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src_mem  [NR][4];
    logic       src_last [NR][4];
    int         src_len  [NR];
    int         src_pos  [NR];
    bit         src_en   [NR];
    bit         force_all;
    logic       rst_v;
    logic       rdy_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            src_en[i]  = 1'b0;
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] d, input logic l);
        src_mem[s][src_len[s]]  = d;
        src_last[s][src_len[s]] = l;
        src_len[s]++;
    endtask

    // Apply source-model outputs and control inputs; called just after a falling edge.
    task automatic drive();
        rst           = rst_v;
        tx_data_ready = rdy_v;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = force_all;
            req_data[i*WL +: WL]  = 8'h00;
            req_last[i]           = 1'b0;
            if (src_en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i]         = 1'b1;
                req_data[i*WL +: WL] = src_mem[i][src_pos[i]];
                req_last[i]          = src_last[i][src_pos[i]];
            end
        end
    endtask

    // Observe handshakes that the coming rising edge will complete.
    task automatic monitor();
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (tx_data_valid && tx_data_ready && !rst) begin
            if (exp_q.size() == 0) check("tx_extra_byte", 32'(tx_data_valid & tx_data_ready), 0);
            else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i] && !force_all && !rst) src_pos[i]++;
        end
    endtask

    // Advance one cycle; returns at the sampling point 2 units after the falling edge.
    task automatic tick();
        @(negedge clk);
        drive();
        #2;
        monitor();
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 32'd1);
        check({tag, "_all_sent"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        clear_srcs();
        force_all = 1'b1;
        rst_v     = 1'b1;
        rdy_v     = 1'b0;
        drive();

        // 1: reset with every source requesting
        tick();
        check("rst_outs_a", {tx_data, tx_data_valid, req_ready, busy, grant_id}, 0);
        tick();
        check("rst_outs_b", {tx_data, tx_data_valid, req_ready, busy, grant_id}, 0);
        rst_v = 1'b0;
        tick();
        check("post_rst_outs", {tx_data, tx_data_valid, req_ready, busy, grant_id}, 0);
        force_all = 1'b0;
        rst_v     = 1'b1;
        tick();
        check("first_grant", {busy, grant_id}, {1'b1, 2'd0});
        rst_v = 1'b0;
        tick();
        check("rst_again_idle", 32'(busy), 0);

        // 2: two-byte packet from source 1, then a measured idle gap
        rdy_v = 1'b1;
        add_byte(1, 8'hA5, 1'b0);
        add_byte(1, 8'h3C, 1'b1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        src_en[1] = 1'b1;
        tick();
        tick();
        check("t2_grant", 32'(grant_id), 1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("t2_bytes_sent", 32'(exp_q.size()), 0);
        tick();
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("t2_gap_len", n, GAP);

        // 3: all sources requesting one-byte packets -> 0,1,2,3,0,1
        clear_srcs();
        do_reset();
        add_byte(0, 8'h10, 1'b1);
        add_byte(0, 8'h11, 1'b1);
        add_byte(1, 8'h20, 1'b1);
        add_byte(1, 8'h21, 1'b1);
        add_byte(2, 8'h30, 1'b1);
        add_byte(3, 8'h40, 1'b1);
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21};
        for (int i = 0; i < NR; i++) src_en[i] = 1'b1;
        wait_idle(300, "t3");

        // 4: UART stalled 20 cycles holding 0x55
        clear_srcs();
        rdy_v = 1'b0;
        add_byte(0, 8'h55, 1'b0);
        add_byte(0, 8'h66, 1'b1);
        exp_q = '{8'h55, 8'h66};
        src_en[0] = 1'b1;
        n = 0;
        while (!tx_data_valid && n < 10) begin
            tick();
            n++;
        end
        check("t4_loaded", 32'(tx_data_valid), 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t4_hold", {tx_data_valid, tx_data, req_ready}, {1'b1, 8'h55, 4'b0000});
        end
        rdy_v = 1'b1;
        wait_idle(60, "t4");
        check("t4_src_consumed", src_pos[0], 2);

        // 5: source 2 waits behind a 3-byte packet from source 0 plus the gap
        clear_srcs();
        do_reset();
        add_byte(0, 8'h01, 1'b0);
        add_byte(0, 8'h02, 1'b0);
        add_byte(0, 8'h03, 1'b1);
        add_byte(2, 8'hC0, 1'b1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'hC0};
        src_en[0] = 1'b1;
        src_en[2] = 1'b1;
        n = 0;
        tick();
        while (!(exp_q.size() == 1 && !busy) && n < 80) begin
            check("t5_src2_blocked", 32'(req_ready[2]), 0);
            tick();
            n++;
        end
        check("t5_src0_done", 32'(n < 80), 1);
        tick();
        check("t5_grant2", {grant_id, req_ready}, {2'd2, 4'b0100});
        wait_idle(60, "t5");

        // 6: reset with a byte pending discards it; arbitration restarts at source 0
        clear_srcs();
        rdy_v = 1'b0;
        add_byte(1, 8'h77, 1'b0);
        add_byte(1, 8'h78, 1'b1);
        src_en[1] = 1'b1;
        n = 0;
        while (!tx_data_valid && n < 10) begin
            tick();
            n++;
        end
        check("t6_pending", {tx_data_valid, tx_data}, {1'b1, 8'h77});
        src_en[1] = 1'b0;
        exp_q.delete();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        rdy_v = 1'b1;
        add_byte(0, 8'hE0, 1'b1);
        add_byte(3, 8'hE3, 1'b1);
        exp_q = '{8'hE0, 8'hE3};
        src_en[0] = 1'b1;
        src_en[3] = 1'b1;
        tick();
        check("t6_flushed", {tx_data_valid, busy, grant_id}, 0);
        tick();
        check("t6_restart_src0", {busy, grant_id}, {1'b1, 2'd0});
        wait_idle(80, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
